// File: rtl/hamming_pkg.sv
// Shared definitions for the hamming register and its scrub controller.
package hamming_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 16;
    localparam int unsigned SCRUB_PERIOD_DEF = 64;
    localparam int unsigned CNT_WIDTH_DEF    = 8;
    localparam int unsigned BURST_WINDOW_DEF = 16;
    localparam int unsigned BURST_THRESH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        SETTLE    = 2'd2
    } scrub_state_t;

endpackage

// File: rtl/hamming_sat_counter.sv
// Saturating up-counter with synchronous clear; when clear and increment
// coincide, the clear is applied first and the increment lands on top of it.
module hamming_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear, then increment unless already at all-ones.
    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q;
        if (inc_i && (cnt_d != '1)) begin
            cnt_d = cnt_d + ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hamming_scrubber.sv
// Scrub controller owning the hamming register write port: passes user writes
// straight through, writes back corrected words on detected errors, refreshes
// periodically, counts corrections and flags bursts of upsets.
module hamming_scrubber
    import hamming_pkg::*;
#(
    parameter int unsigned data_width   = DATA_WIDTH_DEF,
    parameter int unsigned SCRUB_PERIOD = SCRUB_PERIOD_DEF,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int unsigned BURST_WINDOW = BURST_WINDOW_DEF,
    parameter int unsigned BURST_THRESH = BURST_THRESH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wren,
    input  logic [data_width-1:0] wdata,
    input  logic [data_width-1:0] rdata_in,
    input  logic                  err_in,
    input  logic                  alarm_clr,
    output logic                  reg_wren,
    output logic [data_width-1:0] reg_wdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  burst_alarm
);

    localparam int unsigned RW = $clog2(SCRUB_PERIOD);
    localparam int unsigned GW = $clog2(BURST_WINDOW + 1);
    localparam int unsigned BW = $clog2(BURST_THRESH + 1);

    localparam logic [RW-1:0] REF_LAST = RW'(SCRUB_PERIOD - 1);
    localparam logic [RW-1:0] REF_ONE  = RW'(1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(BURST_WINDOW);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [BW-1:0] THRESH   = BW'(BURST_THRESH);

    scrub_state_t          state_q, state_d;
    logic [data_width-1:0] capt_q, capt_d;
    logic [RW-1:0]         ref_q, ref_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  alarm_q, alarm_d;
    logic                  detect;
    logic                  gap_expire;
    logic [BW-1:0]         burst_cnt;

    // Next state, capture and detection; a refresh defers to a concurrent
    // user write, which rewrites the word anyway and restarts the timer.
    always_comb begin
        state_d = state_q;
        capt_d  = capt_q;
        detect  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (err_in && !wren) begin
                    detect  = 1'b1;
                    capt_d  = rdata_in;
                    state_d = WRITEBACK;
                end else if (!wren && (ref_q == REF_LAST)) begin
                    capt_d  = rdata_in;
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: state_d = SETTLE;
            SETTLE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Refresh timer runs only while idle and quiet; gap timer parks at the window.
    always_comb begin
        ref_d = '0;
        if ((state_q == IDLE) && (state_d == IDLE) && !reg_wren) begin
            ref_d = ref_q + REF_ONE;
        end
        gap_expire = (gap_q == GAP_MAX);
        gap_d      = detect ? '0 : (gap_expire ? gap_q : gap_q + GAP_ONE);
        alarm_d    = (alarm_q || (burst_cnt >= THRESH)) && !alarm_clr;
    end

    // State, capture, timers and sticky alarm registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            capt_q  <= '0;
            ref_q   <= '0;
            gap_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            capt_q  <= capt_d;
            ref_q   <= ref_d;
            gap_q   <= gap_d;
            alarm_q <= alarm_d;
        end
    end

    hamming_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (1'b0),
        .inc_i (detect),
        .cnt_o (err_count)
    );

    hamming_sat_counter #(.WIDTH(BW)) u_burst_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (alarm_clr || gap_expire),
        .inc_i (detect),
        .cnt_o (burst_cnt)
    );

    // The count itself feeds the alarm so it rises on the detection edge;
    // the sticky bit holds it once the count is cleared by the gap timer.
    assign burst_alarm = alarm_q || (burst_cnt >= THRESH);
    assign reg_wren    = wren || (state_q == WRITEBACK);
    assign reg_wdata   = wren ? wdata : capt_q;
    assign busy        = (state_q != IDLE);

endmodule
